// File: rtl/upscale_seq.sv
// Sequencing controller for a 2x nearest-neighbour upscaler.
// Fills an external line buffer with one input row, then replays it as two
// output rows with every pixel doubled horizontally. Pixel data never passes
// through this block; it only drives addresses, handshakes and framing flags.
module upscale_seq #(
    parameter int unsigned IN_W = 8,
    parameter int unsigned IN_H = 8,
    parameter int unsigned XW   = 4,
    parameter int unsigned YW   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          lb_we,
    output logic [XW-1:0] lb_waddr,
    output logic [XW-1:0] lb_raddr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y,
    output logic          out_sof,
    output logic          out_eol,
    output logic          out_eof
);

    localparam logic [XW-1:0] WLast = XW'(IN_W - 1);
    localparam logic [XW-1:0] XLast = XW'(2 * IN_W - 1);
    localparam logic [YW-1:0] HLast = YW'(IN_H - 1);

    typedef enum logic [1:0] {StIdle, StFill, StEmit, StDone} state_e;

    state_e        state_q, state_d;
    logic [XW-1:0] wx_q, wx_d;
    logic [XW-1:0] ox_q, ox_d;
    logic          rep_q, rep_d;
    logic [YW-1:0] row_q, row_d;

    logic fill, emit, eol;

    assign fill = (state_q == StFill);
    assign emit = (state_q == StEmit);
    assign eol  = (ox_q == XLast);

    // Next-state and counter updates; handshakes only matter in their own state.
    always_comb begin
        state_d = state_q;
        wx_d    = wx_q;
        ox_d    = ox_q;
        rep_d   = rep_q;
        row_d   = row_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFill;
                    wx_d    = '0;
                    ox_d    = '0;
                    rep_d   = 1'b0;
                    row_d   = '0;
                end
            end
            StFill: begin
                if (in_valid) begin
                    if (wx_q == WLast) begin
                        wx_d    = '0;
                        ox_d    = '0;
                        rep_d   = 1'b0;
                        state_d = StEmit;
                    end else begin
                        wx_d = wx_q + XW'(1);
                    end
                end
            end
            StEmit: begin
                if (out_ready) begin
                    if (eol) begin
                        ox_d = '0;
                        if (!rep_q) begin
                            rep_d = 1'b1;
                        end else if (row_q == HLast) begin
                            state_d = StDone;
                        end else begin
                            row_d   = row_q + YW'(1);
                            rep_d   = 1'b0;
                            state_d = StFill;
                        end
                    end else begin
                        ox_d = ox_q + XW'(1);
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and counter registers; reset abandons any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wx_q    <= '0;
            ox_q    <= '0;
            rep_q   <= 1'b0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            wx_q    <= wx_d;
            ox_q    <= ox_d;
            rep_q   <= rep_d;
            row_q   <= row_d;
        end
    end

    // Moore outputs decoded from registers; positional outputs are forced to
    // zero outside their active state so stale counters never leak out.
    always_comb begin
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        in_ready  = fill;
        out_valid = emit;
        lb_waddr  = fill ? wx_q : '0;
        lb_raddr  = emit ? (ox_q >> 1) : '0;
        out_x     = emit ? ox_q : '0;
        out_y     = emit ? YW'({row_q, rep_q}) : '0;
        out_sof   = emit & (ox_q == '0) & !rep_q & (row_q == '0);
        out_eol   = emit & eol;
        out_eof   = emit & eol & rep_q & (row_q == HLast);
    end

    // The only combinational path from an input: write strobe on accept.
    assign lb_we = in_valid & in_ready;

endmodule

// File: tb/tb_upscale_seq.sv
// Self-checking bench for upscale_seq. The bench plays the external line
// buffer and predicts every handshake, address and pixel from frame-level
// counts of accepted input and output pixels.
module tb_upscale_seq;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int XW   = 4;
    localparam int YW   = 4;
    localparam int OUTN = 4 * W * H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          busy, done, in_ready, lb_we, out_valid;
    logic          out_sof, out_eol, out_eof;
    logic [XW-1:0] lb_waddr, lb_raddr, out_x;
    logic [YW-1:0] out_y;

    logic          start_b = 1'b0;
    logic          in_valid_b = 1'b0;
    logic          out_ready_b = 1'b0;
    logic [7:0]    in_data_b = 8'h00;
    logic          busy_b, done_b, in_ready_b, lb_we_b, out_valid_b;
    logic          out_sof_b, out_eol_b, out_eof_b;
    logic [XW-1:0] lb_waddr_b, lb_raddr_b, out_x_b;
    logic [YW-1:0] out_y_b;

    logic [7:0] lbm   [16];
    logic [7:0] lbm_b [16];

    int total = 0;
    int bad   = 0;

    upscale_seq #(.IN_W(W), .IN_H(H), .XW(XW), .YW(YW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .lb_we(lb_we),
        .lb_waddr(lb_waddr), .lb_raddr(lb_raddr), .out_valid(out_valid),
        .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof)
    );

    upscale_seq #(.IN_W(W), .IN_H(1), .XW(XW), .YW(YW)) dut_h1 (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .lb_we(lb_we_b),
        .lb_waddr(lb_waddr_b), .lb_raddr(lb_raddr_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_x(out_x_b), .out_y(out_y_b),
        .out_sof(out_sof_b), .out_eol(out_eol_b), .out_eof(out_eof_b)
    );

    initial forever #5 clk = ~clk;

    // One whole frame against the count-based model. Cycle 0 is the IDLE
    // cycle carrying start; 'cycles' counts start cycle through done cycle.
    task automatic run_frame(input int rdy_pct, input int vld_pct, input bit noise,
                             input bit seq, output int cycles);
        logic [7:0] pix [W*H];
        logic [XW+YW+XW+2:0] held, now;
        int  nin = 0, nout = 0, k, x, yr;
        bit  seen = 0, stall = 0, exp_ir, exp_ov, exp_dn;
        held   = '0;
        cycles = 0;
        for (int i = 0; i < W * H; i++) pix[i] = seq ? 8'(i + 1) : 8'($urandom);
        @(negedge clk);
        start     = 1'b1;
        in_valid  = 1'($urandom % 2);
        out_ready = 1'b1;
        #1;
        total++;
        if ({busy, done, in_ready, lb_we, out_valid} !== 5'b0) begin
            bad++;
            $display("FAIL idle_before_start: got %b want 00000",
                     {busy, done, in_ready, lb_we, out_valid});
        end
        for (int c = 1; c < 2000 && !seen; c++) begin
            @(negedge clk);
            exp_ir    = (nin < W * H) && (nout == 4 * W * (nin / W));
            exp_ov    = nout < 4 * W * (nin / W);
            exp_dn    = (nout == OUTN);
            start     = noise && (exp_dn || ($urandom % 2 == 1));
            in_valid  = int'($urandom % 100) < vld_pct;
            out_ready = int'($urandom % 100) < rdy_pct;
            in_data   = (nin < W * H) ? pix[nin] : 8'($urandom);
            #1;
            total++;
            if ({busy, done, in_ready, out_valid} !== {1'b1, exp_dn, exp_ir, exp_ov}) begin
                bad++;
                $display("FAIL ctrl c=%0d: busy/done/in_ready/out_valid got %b want %b", c,
                         {busy, done, in_ready, out_valid}, {1'b1, exp_dn, exp_ir, exp_ov});
            end
            total++;
            if (lb_we !== (in_valid & exp_ir)) begin
                bad++;
                $display("FAIL lb_we c=%0d: got %b want %b", c, lb_we, in_valid & exp_ir);
            end
            if (lb_we === 1'b1) begin
                total++;
                if (lb_waddr !== XW'(nin % W)) begin
                    bad++;
                    $display("FAIL lb_waddr c=%0d: got %0d want %0d", c, lb_waddr, nin % W);
                end
                lbm[lb_waddr] = in_data;
                nin++;
            end
            if (out_valid === 1'b1 && nout < OUTN) begin
                now = {out_x, out_y, lb_raddr, out_sof, out_eol, out_eof};
                if (stall) begin
                    total++;
                    if (now !== held) begin
                        bad++;
                        $display("FAIL hold c=%0d: got %h want %h", c, now, held);
                    end
                end
                k  = nout;
                x  = k % (2 * W);
                yr = k / (2 * W);
                total++;
                if (out_x !== XW'(x) || out_y !== YW'(yr)) begin
                    bad++;
                    $display("FAIL coord k=%0d: got x=%0d y=%0d want x=%0d y=%0d", k, out_x,
                             out_y, x, yr);
                end
                total++;
                if (lbm[lb_raddr] !== pix[(yr / 2) * W + x / 2]) begin
                    bad++;
                    $display("FAIL pixel k=%0d: got %h want %h", k, lbm[lb_raddr],
                             pix[(yr / 2) * W + x / 2]);
                end
                total++;
                if ({out_sof, out_eol, out_eof} !== {k == 0, x == 2 * W - 1, k == OUTN - 1}) begin
                    bad++;
                    $display("FAIL flags k=%0d: sof/eol/eof got %b want %b", k,
                             {out_sof, out_eol, out_eof}, {k == 0, x == 2 * W - 1, k == OUTN - 1});
                end
                stall = !out_ready;
                held  = now;
                if (out_ready) nout++;
            end else begin
                stall = 0;
            end
            if (done === 1'b1) begin
                seen   = 1;
                cycles = c + 1;
            end
        end
        start = 1'b0;
        total++;
        if (!seen || nin != W * H || nout != OUTN) begin
            bad++;
            $display("FAIL frame_end: done=%0b in=%0d out=%0d want done=1 in=%0d out=%0d",
                     seen, nin, nout, W * H, OUTN);
        end
    endtask

    task automatic test_reset();
        #3;
        start       = 1'b1;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        start_b     = 1'b1;
        in_valid_b  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            total++;
            if ({busy, done, in_ready, lb_we, lb_waddr, lb_raddr, out_valid, out_x, out_y,
                 out_sof, out_eol, out_eof} !== '0) begin
                bad++;
                $display("FAIL reset_outputs: some output nonzero busy=%b in_ready=%b we=%b",
                         busy, in_ready, lb_we);
            end
        end
        @(negedge clk);
        rst_n      = 1'b1;
        start      = 1'b0;
        in_valid   = 1'b0;
        start_b    = 1'b0;
        in_valid_b = 1'b0;
    endtask

    task automatic test_full();
        int cyc;
        run_frame(100, 100, 1'b0, 1'b1, cyc);
        total++;
        if (cyc != 1 + H * 5 * W + 1) begin
            bad++;
            $display("FAIL full_latency: got %0d cycles want %0d", cyc, 1 + H * 5 * W + 1);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        run_frame(50, 100, 1'b0, 1'b1, cyc);
        run_frame(30, 100, 1'b0, 1'b0, cyc);
    endtask

    task automatic test_bubbles();
        int cyc;
        run_frame(100, 50, 1'b0, 1'b0, cyc);
        run_frame(70, 30, 1'b0, 1'b0, cyc);
    endtask

    // start is hammered through FILL/EMIT/DONE; the next frame begins the
    // cycle right after done.
    task automatic test_start_noise();
        int cyc;
        run_frame(60, 70, 1'b1, 1'b0, cyc);
        run_frame(100, 100, 1'b0, 1'b1, cyc);
        total++;
        if (cyc != 1 + H * 5 * W + 1) begin
            bad++;
            $display("FAIL restart_latency: got %0d cycles want %0d", cyc, 1 + H * 5 * W + 1);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit hit = 0;
        @(negedge clk);
        start     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (out_valid === 1'b1 && out_y === YW'(3) && out_x === XW'(5)) hit = 1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL reach_mid_emit: got no out_y=3 out_x=5 want it within 200 cycles");
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, in_ready, lb_we, lb_waddr, lb_raddr, out_valid, out_x, out_y,
             out_sof, out_eol, out_eof} !== '0) begin
            bad++;
            $display("FAIL async_reset: outputs not cleared busy=%b valid=%b x=%0d y=%0d",
                     busy, out_valid, out_x, out_y);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            total++;
            if ({busy, done, out_valid} !== 3'b0) begin
                bad++;
                $display("FAIL reset_hold: busy/done/valid got %b want 000",
                         {busy, done, out_valid});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(100, 100, 1'b0, 1'b1, cyc);
    endtask

    // Single-row frame on the second instance: two output rows, no re-fill.
    task automatic test_h1();
        logic [7:0] pix [W];
        int  nin = 0, nout = 0, x;
        bit  seen = 0;
        for (int i = 0; i < W; i++) pix[i] = 8'($urandom);
        @(negedge clk);
        start_b     = 1'b1;
        in_valid_b  = 1'b1;
        out_ready_b = 1'b1;
        for (int c = 1; c < 500 && !seen; c++) begin
            @(negedge clk);
            start_b     = 1'b0;
            out_ready_b = 1'($urandom % 2);
            in_data_b   = (nin < W) ? pix[nin] : 8'($urandom);
            #1;
            total++;
            if ({busy_b, in_ready_b} !== {1'b1, nin < W}) begin
                bad++;
                $display("FAIL h1_ctrl c=%0d: busy/in_ready got %b want %b", c,
                         {busy_b, in_ready_b}, {1'b1, nin < W});
            end
            if (lb_we_b === 1'b1) begin
                total++;
                if (lb_waddr_b !== XW'(nin)) begin
                    bad++;
                    $display("FAIL h1_waddr: got %0d want %0d", lb_waddr_b, nin);
                end
                lbm_b[lb_waddr_b] = in_data_b;
                nin++;
            end
            if (out_valid_b === 1'b1 && nout < 4 * W) begin
                x = nout % (2 * W);
                total++;
                if (lbm_b[lb_raddr_b] !== pix[x / 2] || out_x_b !== XW'(x) ||
                    out_y_b !== YW'(nout / (2 * W)) ||
                    {out_sof_b, out_eol_b, out_eof_b} !==
                    {nout == 0, x == 2 * W - 1, nout == 4 * W - 1}) begin
                    bad++;
                    $display("FAIL h1_out k=%0d: got pix=%h x=%0d y=%0d f=%b want pix=%h x=%0d",
                             nout, lbm_b[lb_raddr_b], out_x_b, out_y_b,
                             {out_sof_b, out_eol_b, out_eof_b}, pix[x / 2], x);
                end
                if (out_ready_b) nout++;
            end
            if (done_b === 1'b1) seen = 1;
        end
        in_valid_b = 1'b0;
        total++;
        if (!seen || nout != 4 * W || nin != W) begin
            bad++;
            $display("FAIL h1_end: done=%0b out=%0d in=%0d want done=1 out=%0d in=%0d",
                     seen, nout, nin, 4 * W, W);
        end
    endtask

    initial begin
        test_reset();
        test_full();
        test_backpressure();
        test_bubbles();
        test_start_noise();
        test_reset_mid();
        test_h1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
